uart_tx: RTL and testbench

Asynchronous serial transmitter: accepts one byte at a time over a valid/ready handshake and shifts it out on the `usb_tx` line as an 8N1 frame, LSB first. It is the transmit counterpart of the existing receiver on the USB-UART bridge, instantiated in the top level next to it and sharing the same clock and reset. Bit timing is derived from the system clock by an integer divider.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state enum, data width and bit-period helper.
// Used by both the transmitter and the receiver on the USB-UART bridge.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;

  // Integer bit period in system clocks; the fractional part is dropped.
  function automatic int calc_clks_per_bit(input int clock_rate, input int baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses bit_tick on the
// terminal count. A synchronous clear holds it at zero between frames.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || (count == TERMINAL)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign bit_tick = !clear && (count == TERMINAL);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input, LSB first on usb_tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       usb_tx
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_RATE, BAUD_RATE);
  localparam int BIT_CNT_W = $clog2(UART_DATA_BITS);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(UART_DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx: CLOCK_RATE/BAUD_RATE must be at least 2");
    end
  endgenerate

  uart_state_t state, state_next;
  logic [UART_DATA_BITS-1:0] shift, shift_next;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic line_next;
  logic ready_next;
  logic bit_tick;
  logic baud_clear;

`ifdef UART_TX_PARITY_EN
  logic parity, parity_next;
`endif

  // Holding the divider in clear while idle makes every frame start at count 0.
  assign baud_clear = (state == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (baud_clear),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    line_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity;
`endif

    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          shift_next   = tx_data;
          bit_cnt_next = '0;
          state_next   = START;
`ifdef UART_TX_PARITY_EN
          parity_next  = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_next = {1'b0, shift[UART_DATA_BITS-1:1]};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
          end
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (bit_tick) state_next = STOP;
`else
        state_next = IDLE;
`endif
      end
      STOP: begin
        if (bit_tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Outputs are registered from the upcoming state so they change with it.
    case (state_next)
      START:  line_next = 1'b0;
      DATA:   line_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY: line_next = parity_next;
`endif
      default: line_next = 1'b1;
    endcase

    ready_next = (state_next == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      usb_tx   <= 1'b1;
      tx_ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      shift    <= shift_next;
      bit_cnt  <= bit_cnt_next;
      usb_tx   <= line_next;
      tx_ready <= ready_next;
`ifdef UART_TX_PARITY_EN
      parity   <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit; expected line patterns are
// hand-written per byte. Honours UART_TX_PARITY_EN for the 11-bit frame.
module tb_uart_tx;

  localparam int CLKS = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int SPACING = FRAME_BITS * CLKS + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       usb_tx;

  uart_tx #(
    .CLOCK_RATE(1000000),
    .BAUD_RATE (100000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .usb_tx  (usb_tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int accept_cyc[$];

  always @(posedge clk) begin
    cyc++;
    if (rst_n && tx_valid && tx_ready) accept_cyc.push_back(cyc);
  end

  // frame[i] is the i-th line level in time: start, d0..d7, (parity), stop.
  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Starts at the negedge of the first start-bit cycle, ends at the idle negedge after.
  task automatic check_frame(input logic [10:0] frame, input string name, input int inject_bit);
    int bad;
    int ready_bad;
    ready_bad = 0;
    for (int b = 0; b < FRAME_BITS; b++) begin
      bad = 0;
      for (int c = 0; c < CLKS; c++) begin
        if (b == inject_bit && c == 0) begin
          tx_data  = 8'hF0;
          tx_valid = 1'b1;
        end
        if (usb_tx !== frame[b]) bad++;
        if (tx_ready !== 1'b0) ready_bad++;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d wrong-level cycles", name, b), bad, 0);
    end
    chk($sformatf("%s tx_ready high inside frame", name), ready_bad, 0);
    chk($sformatf("%s tx_ready after frame", name), {31'b0, tx_ready}, 1);
    chk($sformatf("%s line idle after frame", name), {31'b0, usb_tx}, 1);
  endtask

  task automatic accept(input logic [7:0] d, input string name);
    int n;
    n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk($sformatf("%s wait for tx_ready", name), 0, 1);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_tx, bad_rdy, n0;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'h55, 11'b1_0_01010101_0};
    vecs[1] = '{8'hA3, 11'b1_0_10100011_0};
    vecs[2] = '{8'h00, 11'b1_0_00000000_0};
    vecs[3] = '{8'h0F, 11'b1_0_00001111_0};
    vecs[4] = '{8'hF0, 11'b1_0_11110000_0};
    vecs[5] = '{8'h81, 11'b1_0_10000001_0};
    vecs[6] = '{8'h07, 11'b1_1_00000111_0};
    vecs[7] = '{8'h03, 11'b1_0_00000011_0};
`else
    vecs[0] = '{8'h55, 11'b1_1_01010101_0};
    vecs[1] = '{8'hA3, 11'b1_1_10100011_0};
    vecs[2] = '{8'h00, 11'b1_1_00000000_0};
    vecs[3] = '{8'h0F, 11'b1_1_00001111_0};
    vecs[4] = '{8'hF0, 11'b1_1_11110000_0};
    vecs[5] = '{8'h81, 11'b1_1_10000001_0};
    vecs[6] = '{8'h07, 11'b1_1_00000111_0};
    vecs[7] = '{8'h03, 11'b1_1_00000011_0};
`endif

    // Reset state and long idle
    repeat (3) @(negedge clk);
    chk("reset usb_tx", {31'b0, usb_tx}, 1);
    chk("reset tx_ready", {31'b0, tx_ready}, 1);
    rst_n = 1'b1;
    bad_tx = 0;
    bad_rdy = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (usb_tx !== 1'b1) bad_tx++;
      if (tx_ready !== 1'b1) bad_rdy++;
    end
    chk("idle usb_tx low cycles", bad_tx, 0);
    chk("idle tx_ready low cycles", bad_rdy, 0);

    // Table-driven single frames
    for (int i = 0; i < 8; i++) begin
      accept(vecs[i].data, $sformatf("byte %02h", vecs[i].data));
      check_frame(vecs[i].frame, $sformatf("byte %02h", vecs[i].data), -1);
      repeat (3) @(negedge clk);
    end

    // Back-to-back with tx_valid held: A3 then 00
    n0 = accept_cyc.size();
    tx_data  = 8'hA3;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_data = 8'h00;
    check_frame(vecs[1].frame, "b2b A3", -1);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    check_frame(vecs[2].frame, "b2b 00", -1);
    repeat (5) @(negedge clk);
    chk("b2b acceptance count", accept_cyc.size() - n0, 2);
    if (accept_cyc.size() >= n0 + 2)
      chk("b2b start spacing", accept_cyc[n0+1] - accept_cyc[n0], SPACING);

    // Data change mid-frame: 0F on the line, F0 offered during bit 3
    n0 = accept_cyc.size();
    accept(8'h0F, "midchg 0F");
    check_frame(vecs[3].frame, "midchg 0F", 4);
    chk("midchg accepts during frame", accept_cyc.size() - n0, 1);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    check_frame(vecs[4].frame, "midchg F0", -1);
    chk("midchg acceptance count", accept_cyc.size() - n0, 2);
    if (accept_cyc.size() >= n0 + 2)
      chk("midchg F0 accept spacing", accept_cyc[n0+1] - accept_cyc[n0], SPACING);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of data bit 4
    accept(8'h00, "reset frame");
    repeat (53) @(negedge clk);
    chk("pre-reset line low", {31'b0, usb_tx}, 0);
    chk("pre-reset tx_ready low", {31'b0, tx_ready}, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset usb_tx", {31'b0, usb_tx}, 1);
    chk("async reset tx_ready", {31'b0, tx_ready}, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad_tx = 0;
    bad_rdy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (usb_tx !== 1'b1) bad_tx++;
      if (tx_ready !== 1'b1) bad_rdy++;
    end
    chk("post-reset usb_tx low cycles", bad_tx, 0);
    chk("post-reset tx_ready low cycles", bad_rdy, 0);
    accept(8'h81, "post-reset 81");
    check_frame(vecs[5].frame, "post-reset 81", -1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
